// File: rtl/seq_mod3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mod3_pkg
// Purpose  : Shared types and mod-3 helpers for the serial mod-3 generator
//            and detector.
// Revision : 1.0 - initial release
// ============================================================================
package seq_mod3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHK1  = 2'd2,
        CHK0  = 2'd3
    } state_t;

    typedef logic [1:0] residue_t;

    // (2r + b) mod 3, tabulated so no divider is inferred.
    function automatic residue_t residue_next(input residue_t r, input logic b);
        case (r)
            2'd0:    residue_next = b ? 2'd1 : 2'd0;
            2'd1:    residue_next = b ? 2'd0 : 2'd2;
            default: residue_next = b ? 2'd2 : 2'd1;
        endcase
    endfunction

    // Two appended bits that bring residue r back to 0: c = (3 - r) mod 3.
    function automatic logic [1:0] check_bits(input residue_t r);
        case (r)
            2'd1:    check_bits = 2'b10;
            2'd2:    check_bits = 2'b01;
            default: check_bits = 2'b00;
        endcase
    endfunction

endpackage : seq_mod3_pkg
`default_nettype wire

// File: rtl/mod3_residue.sv
`default_nettype none
// ============================================================================
// Module   : mod3_residue
// Purpose  : Bit-serial mod-3 residue register, MSB-first accumulation.
// Revision : 1.0 - initial release
// ============================================================================
module mod3_residue
    import seq_mod3_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr,
    input  logic     en,
    input  logic     bit_in,
    output residue_t r
);

    residue_t r_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= 2'd0;
        end else if (clr) begin
            r_res <= 2'd0;
        end else if (en) begin
            r_res <= residue_next(r_res, bit_in);
        end
    end

    assign r = r_res;

endmodule : mod3_residue
`default_nettype wire

// File: rtl/seq_mod3_generator.sv
`default_nettype none
// ============================================================================
// Module   : seq_mod3_generator
// Purpose  : Serializes WIDTH-bit words MSB-first and appends two check bits
//            so each frame, read as a binary number, is a multiple of 3.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mod3_generator
    import seq_mod3_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             data,
    output logic             frame,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-2:0] r_shreg;
    logic             r_data;
    logic             r_frame;
    logic             r_last;
    logic             r_chk0;

    residue_t         w_res;
    residue_t         w_res_full;
    logic [1:0]       w_chk_final;
    logic             w_accept;

    // Residue follows the bit currently on the line; cleared on accept.
    mod3_residue u_residue (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_accept),
        .en     (r_state == SHIFT),
        .bit_in (r_data),
        .r      (w_res)
    );

    assign in_ready    = (r_state == IDLE) || (r_state == CHK0);
    assign w_accept    = in_valid && in_ready;
    // Includes the payload bit on the line now, so CHK1 can be launched this edge.
    assign w_res_full  = residue_next(w_res, r_data);
    assign w_chk_final = check_bits(w_res_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_data  <= 1'b0;
            r_frame <= 1'b0;
            r_last  <= 1'b0;
            r_chk0  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, CHK0: begin
                    if (w_accept) begin
                        r_state <= SHIFT;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_data  <= in_data[WIDTH-1];
                        r_shreg <= in_data[WIDTH-2:0];
                        r_frame <= 1'b1;
                        r_last  <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        r_data  <= 1'b0;
                        r_frame <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (r_cnt == '0) begin
                        r_state <= CHK1;
                        r_data  <= w_chk_final[1];
                        r_chk0  <= w_chk_final[0];
                    end else begin
                        r_cnt   <= r_cnt - CW'(1);
                        r_data  <= r_shreg[WIDTH-2];
                        r_shreg <= r_shreg << 1;
                    end
                end
                CHK1: begin
                    r_state <= CHK0;
                    r_data  <= r_chk0;
                    r_last  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_data  <= 1'b0;
                    r_frame <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign data  = r_data;
    assign frame = r_frame;
    assign last  = r_last;

endmodule : seq_mod3_generator
`default_nettype wire

// File: tb/tb_seq_mod3_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mod3_generator
// Purpose  : Self-checking bench; per-cycle comparison against a frame queue
//            model plus a running mod-3 loopback check of the serial stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mod3_generator;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         in_ready;
    logic         data;
    logic         frame;
    logic         last;

    int           n_vec    = 0;
    int           n_err    = 0;
    int           accepts  = 0;
    int           cum      = 0;
    logic [2:0]   exp_q[$];   // {data, frame, last} per upcoming cycle

    always #5 clk = ~clk;

    seq_mod3_generator #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .data     (data),
        .frame    (frame),
        .last     (last)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, expv);
        end
    endtask

    function automatic void push_frame(input logic [W-1:0] w);
        int c;
        c = (3 - (int'(w) % 3)) % 3;
        for (int i = W - 1; i >= 0; i--) exp_q.push_back({w[i], 1'b1, 1'b0});
        exp_q.push_back({c[1], 1'b1, 1'b0});
        exp_q.push_back({c[0], 1'b1, 1'b1});
    endfunction

    task automatic step(input logic v, input logic [W-1:0] d);
        logic [2:0] e;
        logic       ready_e;
        @(negedge clk);
        e       = (exp_q.size() > 0) ? exp_q[0] : 3'b000;
        ready_e = (exp_q.size() <= 1);
        check_eq("data",     32'(data),     32'(e[2]));
        check_eq("frame",    32'(frame),    32'(e[1]));
        check_eq("last",     32'(last),     32'(e[0]));
        check_eq("in_ready", 32'(in_ready), 32'(ready_e));
        cum = (2 * cum + ((data === 1'b1) ? 1 : 0)) % 3;
        if (e[0]) check_eq("stream_mod3_at_last", cum, 0);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (v && ready_e) begin
            push_frame(d);
            accepts++;
        end
    endtask

    // Called right after a step, i.e. just past a rising edge.
    task automatic mid_reset();
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_eq("rst_data",     32'(data),     0);
        check_eq("rst_frame",    32'(frame),    0);
        check_eq("rst_last",     32'(last),     0);
        check_eq("rst_in_ready", 32'(in_ready), 1);
        exp_q.delete();
        cum = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int start;
        int budget;

        repeat (2) @(negedge clk);
        check_eq("init_data",     32'(data),     0);
        check_eq("init_frame",    32'(frame),    0);
        check_eq("init_last",     32'(last),     0);
        check_eq("init_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;

        step(1'b1, 8'h01); repeat (11) step(1'b0, '0);
        step(1'b1, 8'h02); repeat (11) step(1'b0, '0);
        step(1'b1, 8'hFF); repeat (11) step(1'b0, '0);

        // Back-to-back: valid held, second word taken on the CHK0 cycle.
        step(1'b1, 8'h01); repeat (10) step(1'b1, 8'h05); repeat (12) step(1'b0, '0);

        // Pulses during SHIFT and CHK1 must be ignored.
        step(1'b1, 8'h0C); step(1'b0, '0); step(1'b1, 8'h33);
        repeat (6) step(1'b0, '0); step(1'b1, 8'h77); repeat (4) step(1'b0, '0);

        // Reset while the 4th payload bit of A5 is on the line.
        step(1'b1, 8'hA5); repeat (3) step(1'b0, '0);
        mid_reset();
        step(1'b1, 8'h03); repeat (11) step(1'b0, '0);

        start  = accepts;
        budget = 0;
        while ((accepts - start) < 200 && budget < 20000) begin
            step($urandom_range(0, 3) != 0, W'($urandom));
            budget++;
        end
        if ((accepts - start) < 200) check_eq("random_accept_budget", accepts - start, 200);
        repeat (12) step(1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seq_mod3_generator
`default_nettype wire
